// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined carry-lookahead adder/subtractor with valid/ready handshake
module cla_pipe_addsub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int SW     = WIDTH / STAGES;
  localparam int GROUPS = SW / 4;

  // One 4-bit lookahead group: all internal carries from generate/propagate.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] cc;
    g     = x & y;
    p     = x ^ y;
    cc[0] = c;
    cc[1] = g[0] | (p[0] & c);
    cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c);
    return {cc[4], p ^ cc[3:0]};
  endfunction

  // One pipeline slice: lookahead groups with the group carry rippled between them.
  function automatic logic [SW:0] slice_add(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                            input logic c);
    logic [SW-1:0] sum;
    logic          carry;
    logic [4:0]    grp;
    sum   = '0;
    carry = c;
    for (int g = 0; g < GROUPS; g++) begin
      grp           = cla4(x[g*4 +: 4], y[g*4 +: 4], carry);
      sum[g*4 +: 4] = grp[3:0];
      carry         = grp[4];
    end
    return {carry, sum};
  endfunction

  // Stage registers, index 0 is the first stage; the last stage drives the outputs.
  logic             st_v [STAGES];
  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_r [STAGES];
  logic             st_c [STAGES];
  logic             ovf_q;

  // What each stage would load on an advance.
  logic             src_v [STAGES];
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_r [STAGES];
  logic             src_c [STAGES];
  logic [WIDTH-1:0] nxt_r [STAGES];
  logic             nxt_c [STAGES];
  logic             nxt_ovf;
  logic [SW:0]      sl;
  logic             adv;

  assign out_valid = st_v[STAGES-1];
  assign s         = st_r[STAGES-1];
  assign co        = st_c[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = (st_r[STAGES-1] == '0);
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  // Route predecessor state into each stage and add that stage's slice.
  always_comb begin
    sl       = '0;
    src_v[0] = in_valid;
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_c[0] = sub ? 1'b1 : ci;
    src_r[0] = '0;
    for (int j = 1; j < STAGES; j++) begin
      src_v[j] = st_v[j-1];
      src_a[j] = st_a[j-1];
      src_b[j] = st_b[j-1];
      src_c[j] = st_c[j-1];
      src_r[j] = st_r[j-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sl                   = slice_add(src_a[k][k*SW +: SW], src_b[k][k*SW +: SW], src_c[k]);
      nxt_r[k]             = src_r[k];
      nxt_r[k][k*SW +: SW] = sl[SW-1:0];
      nxt_c[k]             = sl[SW];
    end
    nxt_ovf = (src_a[STAGES-1][WIDTH-1] == src_b[STAGES-1][WIDTH-1]) &&
              (nxt_r[STAGES-1][WIDTH-1] != src_a[STAGES-1][WIDTH-1]);
  end

  // Global-stall shift: every stage advances together; bubbles load zeroed data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        st_v[k] <= 1'b0;
        st_a[k] <= '0;
        st_b[k] <= '0;
        st_r[k] <= '0;
        st_c[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        st_v[k] <= src_v[k];
        st_a[k] <= src_v[k] ? src_a[k] : '0;
        st_b[k] <= src_v[k] ? src_b[k] : '0;
        st_r[k] <= src_v[k] ? nxt_r[k] : '0;
        st_c[k] <= src_v[k] & nxt_c[k];
      end
      ovf_q <= src_v[STAGES-1] & nxt_ovf;
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb/tb_cla_pipe_addsub.sv - scoreboard bench for cla_pipe_addsub
module tb_cla_pipe_addsub;

  localparam int STAGES = 4;

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ovf;
    int          stamp;
    int          stall;
  } exp_t;

  typedef struct {
    logic [127:0] s;
    logic         co;
    logic         ovf;
    int           stamp;
  } sw_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic        sub;
    logic [63:0] s;
    logic        co;
    logic        ovf;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        ci;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] s;
  logic        co;
  logic        ovf;
  logic        zero;

  logic [127:0] sw_a;
  logic [127:0] sw_b;
  logic         sw_ci;
  logic         sw_sub;
  logic         sw_valid;
  logic [127:0] sw_s   [4];
  logic         sw_co  [4];
  logic         sw_ovf [4];
  logic         sw_zero[4];
  logic         sw_ov  [4];
  logic         sw_ir  [4];

  exp_t exp_q[$];
  sw_t  sw_q[4][$];
  int   cyc;
  int   stall_cnt;
  int   stim_timeouts;
  int   checks;
  int   failures;
  logic chk_idle;
  logic end_req;

  cla_pipe_addsub #(.WIDTH(64), .STAGES(STAGES)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ovf(ovf), .zero(zero)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    localparam int W = (gi == 2) ? 32 : (gi == 3) ? 128 : 64;
    localparam int S = (gi == 0) ? 1 : (gi == 1) ? 16 : (gi == 2) ? 2 : 8;
    logic [W-1:0] s_o;
    logic         ir_o;
    logic         ov_o;
    logic         co_o;
    logic         ovf_o;
    logic         zero_o;
    cla_pipe_addsub #(.WIDTH(W), .STAGES(S)) u_sw (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir_o),
      .a(sw_a[W-1:0]), .b(sw_b[W-1:0]), .ci(sw_ci), .sub(sw_sub),
      .out_valid(ov_o), .out_ready(1'b1),
      .s(s_o), .co(co_o), .ovf(ovf_o), .zero(zero_o)
    );
    assign sw_s[gi]    = 128'(s_o);
    assign sw_co[gi]   = co_o;
    assign sw_ovf[gi]  = ovf_o;
    assign sw_zero[gi] = zero_o;
    assign sw_ov[gi]   = ov_o;
    assign sw_ir[gi]   = ir_o;
  end

  function automatic int sw_width(input int i);
    return (i == 2) ? 32 : (i == 3) ? 128 : 64;
  endfunction

  function automatic int sw_stages(input int i);
    return (i == 0) ? 1 : (i == 1) ? 16 : (i == 2) ? 2 : 8;
  endfunction

  // Behavioural reference: plain wide addition, masked to the operand width.
  function automatic void ref_calc(input int w, input logic [127:0] av, input logic [127:0] bv,
                                   input logic civ, input logic subv,
                                   output logic [127:0] rs, output logic rco, output logic rovf);
    logic [127:0] mask;
    logic [127:0] am;
    logic [127:0] bx;
    logic [128:0] t;
    mask = (w == 128) ? {128{1'b1}} : ((128'(1) << w) - 128'(1));
    am   = av & mask;
    bx   = (subv ? ~bv : bv) & mask;
    t    = {1'b0, am} + {1'b0, bx} + 129'(subv ? 1'b1 : civ);
    rs   = t[127:0] & mask;
    rco  = t[w];
    rovf = (am[w-1] == bx[w-1]) && (rs[w-1] != am[w-1]);
  endfunction

  task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic finish_run();
    chk("stim_timeouts", 132'(stim_timeouts), 132'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Offer one beat for one cycle; on acceptance push its expected result.
  task automatic issue(input logic [63:0] av, input logic [63:0] bv, input logic civ,
                       input logic subv, input logic ordy, input logic [63:0] es,
                       input logic eco, input logic eovf, output logic acc);
    exp_t e;
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    ci        = civ;
    sub       = subv;
    out_ready = ordy;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      e.s     = es;
      e.co    = eco;
      e.ovf   = eovf;
      e.stamp = cyc;
      e.stall = stall_cnt;
      exp_q.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle(input logic ordy);
    in_valid  = 1'b0;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) idle_cycle(1'b1);
    if (exp_q.size() != 0) stim_timeouts++;
  endtask

  task automatic issue_vec(input vec_t v, input logic ordy);
    logic acc;
    acc = 1'b0;
    for (int r = 0; r < 40 && !acc; r++) issue(v.a, v.b, v.ci, v.sub, ordy, v.s, v.co, v.ovf, acc);
    if (!acc) stim_timeouts++;
  endtask

  task automatic issue_rand(input logic ordy);
    vec_t         v;
    logic [127:0] rs;
    v.a   = {$urandom, $urandom};
    v.b   = {$urandom, $urandom};
    v.ci  = 1'($urandom_range(1));
    v.sub = 1'($urandom_range(1));
    ref_calc(64, {64'd0, v.a}, {64'd0, v.b}, v.ci, v.sub, rs, v.co, v.ovf);
    v.s = rs[63:0];
    issue_vec(v, ordy);
  endtask

  // Stimulus
  initial begin
    vec_t         vecs[9];
    vec_t         v;
    logic         acc;
    int           t;
    logic [127:0] rs;
    sw_t          se;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
    vecs[1] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[2] = '{64'd3, 64'd5, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[4] = '{64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0};
    vecs[5] = '{64'd5, 64'd5, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0};
    vecs[6] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0};
    vecs[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1};
    vecs[8] = '{64'd0, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

    cyc = 0; stall_cnt = 0; stim_timeouts = 0; checks = 0; failures = 0;
    chk_idle = 1'b1; end_req = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) idle_cycle(1'b1);
    chk_idle = 1'b0;

    // Directed vectors, back to back
    foreach (vecs[i]) issue_vec(vecs[i], 1'b1);
    drain();

    // 16 random beats with a 3-cycle output stall mid-stream
    t = 0;
    for (int j = 0; j < 16; j++) begin
      v.a   = {$urandom, $urandom};
      v.b   = {$urandom, $urandom};
      v.ci  = 1'($urandom_range(1));
      v.sub = 1'($urandom_range(1));
      ref_calc(64, {64'd0, v.a}, {64'd0, v.b}, v.ci, v.sub, rs, v.co, v.ovf);
      v.s = rs[63:0];
      acc = 1'b0;
      for (int r = 0; r < 20 && !acc; r++) begin
        issue(v.a, v.b, v.ci, v.sub, !(t >= 6 && t <= 8), v.s, v.co, v.ovf, acc);
        t++;
      end
      if (!acc) stim_timeouts++;
    end
    drain();

    // Beats on alternate cycles
    for (int j = 0; j < 4; j++) begin
      issue_rand(1'b1);
      idle_cycle(1'b1);
    end
    drain();

    // Two beats in flight when reset hits; they must never come out
    issue_rand(1'b1);
    idle_cycle(1'b1);
    issue_rand(1'b1);
    rst_n = 1'b0;
    exp_q.delete();
    chk_idle = 1'b1;
    repeat (2) idle_cycle(1'b1);
    rst_n = 1'b1;
    idle_cycle(1'b1);
    chk_idle = 1'b0;
    issue_vec(vecs[1], 1'b1);
    drain();

    // Parameter sweep: same operands into every sweep instance each cycle
    for (int n = 0; n < 1000; n++) begin
      sw_a   = {$urandom, $urandom, $urandom, $urandom};
      sw_b   = {$urandom, $urandom, $urandom, $urandom};
      sw_ci  = 1'($urandom_range(1));
      sw_sub = 1'($urandom_range(1));
      if (n % 100 == 0) begin sw_a = '1; sw_b = 128'd1; sw_sub = 1'b0; sw_ci = 1'b0; end
      if (n % 100 == 1) begin sw_a = '0; sw_b = 128'd1; sw_sub = 1'b1; end
      if (n % 100 == 2) begin sw_a = sw_b; sw_sub = 1'b1; end
      sw_valid = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        ref_calc(sw_width(i), sw_a, sw_b, sw_ci, sw_sub, se.s, se.co, se.ovf);
        se.stamp = cyc;
        sw_q[i].push_back(se);
      end
    end
    sw_valid = 1'b0;
    end_req  = 1'b1;
  end

  // Monitor: all comparisons happen here
  initial begin
    exp_t         e;
    sw_t          se;
    logic         prev_hold;
    logic [63:0]  prev_s;
    logic         prev_co;
    logic         prev_ovf;
    int           end_wait;
    int           pend;
    prev_hold = 1'b0; prev_s = '0; prev_co = 1'b0; prev_ovf = 1'b0; end_wait = 0;
    forever begin
      @(negedge clk);
      if (cyc > 30000) begin
        chk("watchdog", 132'd1, 132'd0);
        finish_run();
      end
      if (chk_idle)
        chk("idle", {out_valid, in_ready, zero, co, ovf, s}, {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0});
      chk("in_ready", 132'(in_ready), 132'(!out_valid || out_ready));
      if (prev_hold && rst_n)
        chk("stable", {out_valid, co, ovf, s}, {1'b1, prev_co, prev_ovf, prev_s});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {co, ovf, s}, 132'd0 - 132'd1);
        end else begin
          e = exp_q.pop_front();
          chk("result", {zero, co, ovf, s}, {e.s == 64'd0, e.co, e.ovf, e.s});
          chk("latency", 132'(cyc), 132'(e.stamp + STAGES - 1 + (stall_cnt - e.stall)));
        end
      end
      prev_hold = rst_n && out_valid && !out_ready;
      prev_s    = s;
      prev_co   = co;
      prev_ovf  = ovf;
      if (out_valid && !out_ready) stall_cnt++;

      for (int i = 0; i < 4; i++) begin
        chk($sformatf("sw%0d_in_ready", i), 132'(sw_ir[i]), 132'd1);
        if (sw_ov[i]) begin
          if (sw_q[i].size() == 0) begin
            chk($sformatf("sw%0d_unexpected_out", i), 132'(sw_s[i]), 132'd0 - 132'd1);
          end else begin
            se = sw_q[i].pop_front();
            chk($sformatf("sw%0d_result", i), {sw_zero[i], sw_co[i], sw_ovf[i], sw_s[i]},
                {se.s == 128'd0, se.co, se.ovf, se.s});
            chk($sformatf("sw%0d_latency", i), 132'(cyc), 132'(se.stamp + sw_stages(i) - 1));
          end
        end
      end

      if (end_req) begin
        pend = exp_q.size() + sw_q[0].size() + sw_q[1].size() + sw_q[2].size() + sw_q[3].size();
        if (pend == 0) finish_run();
        end_wait++;
        if (end_wait > 300) begin
          chk("drain_pending", 132'(pend), 132'd0);
          finish_run();
        end
      end
    end
  end

endmodule
